// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// adder_arbiter : shares one external 32-bit add/sub unit between two ports
// Revision 1.0
// ============================================================================
module adder_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_opr0_i,
  input  logic [31:0] req0_opr1_i,
  input  logic        req0_minus_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_opr0_i,
  input  logic [31:0] req1_opr1_i,
  input  logic        req1_minus_i,
  output logic [31:0] add_opr0_o,
  output logic [31:0] add_opr1_o,
  output logic        add_minus_o,
  input  logic [31:0] add_result_i,
  input  logic        add_zero_i,
  input  logic        add_pos_i,
  input  logic        add_neg_i,
  input  logic        add_ovf_i,
  output logic        resp0_valid_o,
  input  logic        resp0_ready_i,
  output logic [31:0] resp0_result_o,
  output logic [3:0]  resp0_flags_o,
  output logic        resp1_valid_o,
  input  logic        resp1_ready_i,
  output logic [31:0] resp1_result_o,
  output logic [3:0]  resp1_flags_o
);

  logic        last_grant_q, last_grant_d;
  logic        resp0_valid_q, resp0_valid_d, resp1_valid_q, resp1_valid_d;
  logic [31:0] resp0_result_q, resp0_result_d, resp1_result_q, resp1_result_d;
  logic [3:0]  resp0_flags_q, resp0_flags_d, resp1_flags_q, resp1_flags_d;
  logic        elig0, elig1, gnt0, gnt1;
  logic [3:0]  add_flags;

  // A slot frees up in the same cycle its pending response is consumed.
  assign elig0     = req0_valid_i & (~resp0_valid_q | resp0_ready_i);
  assign elig1     = req1_valid_i & (~resp1_valid_q | resp1_ready_i);
  assign add_flags = {add_ovf_i, add_neg_i, add_pos_i, add_zero_i};

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (PRIO_MODE == 1) begin
      gnt0 = elig0;
      gnt1 = elig1 & ~elig0;
    end else if (elig0 && elig1) begin
      gnt0 = last_grant_q;
      gnt1 = ~last_grant_q;
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  always_comb begin
    add_opr0_o  = 32'd0;
    add_opr1_o  = 32'd0;
    add_minus_o = 1'b0;
    if (gnt0) begin
      add_opr0_o  = req0_opr0_i;
      add_opr1_o  = req0_opr1_i;
      add_minus_o = req0_minus_i;
    end else if (gnt1) begin
      add_opr0_o  = req1_opr0_i;
      add_opr1_o  = req1_opr1_i;
      add_minus_o = req1_minus_i;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0)      last_grant_d = 1'b0;
    else if (gnt1) last_grant_d = 1'b1;
  end

  always_comb begin
    resp0_valid_d  = resp0_valid_q;
    resp0_result_d = resp0_result_q;
    resp0_flags_d  = resp0_flags_q;
    if (gnt0) begin
      resp0_valid_d  = 1'b1;
      resp0_result_d = add_result_i;
      resp0_flags_d  = add_flags;
    end else if (resp0_ready_i) begin
      resp0_valid_d  = 1'b0;
    end
  end

  always_comb begin
    resp1_valid_d  = resp1_valid_q;
    resp1_result_d = resp1_result_q;
    resp1_flags_d  = resp1_flags_q;
    if (gnt1) begin
      resp1_valid_d  = 1'b1;
      resp1_result_d = add_result_i;
      resp1_flags_d  = add_flags;
    end else if (resp1_ready_i) begin
      resp1_valid_d  = 1'b0;
    end
  end

  // last_grant resets to 1 so port 0 wins the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q   <= 1'b1;
      resp0_valid_q  <= 1'b0;
      resp0_result_q <= 32'd0;
      resp0_flags_q  <= 4'd0;
      resp1_valid_q  <= 1'b0;
      resp1_result_q <= 32'd0;
      resp1_flags_q  <= 4'd0;
    end else begin
      last_grant_q   <= last_grant_d;
      resp0_valid_q  <= resp0_valid_d;
      resp0_result_q <= resp0_result_d;
      resp0_flags_q  <= resp0_flags_d;
      resp1_valid_q  <= resp1_valid_d;
      resp1_result_q <= resp1_result_d;
      resp1_flags_q  <= resp1_flags_d;
    end
  end

  assign resp0_valid_o  = resp0_valid_q;
  assign resp0_result_o = resp0_result_q;
  assign resp0_flags_o  = resp0_flags_q;
  assign resp1_valid_o  = resp1_valid_q;
  assign resp1_result_o = resp1_result_q;
  assign resp1_flags_o  = resp1_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// tb_adder_arbiter : directed bench, round-robin and fixed-priority instances
// Revision 1.1
// ============================================================================
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        q0v, q1v, q0m, q1m, p0r, p1r;
    logic [31:0] q0a, q0b, q1a, q1b;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        r_q0r, r_q1r, r_am, r_p0v, r_p1v;
    logic [31:0] r_aa, r_ab, r_res, r_p0d, r_p1d;
    logic [3:0]  r_fl, r_p0f, r_p1f;
    logic        f_q0r, f_q1r, f_am, f_p0v, f_p1v;
    logic [31:0] f_aa, f_ab, f_res, f_p0d, f_p1d;
    logic [3:0]  f_fl, f_p0f, f_p1f;

    always #5 clk = ~clk;

    // Reference adder: returns {ovf, neg, pos, zero, result}.
    function automatic logic [35:0] addm(input logic [31:0] a, input logic [31:0] b,
                                         input logic m);
        logic [31:0] r;
        logic        v;
        r = m ? a - b : a + b;
        v = m ? ((a[31] != b[31]) && (r[31] != a[31])) : ((a[31] == b[31]) && (r[31] != a[31]));
        return {v, r[31], ~r[31] & (r != 0), r == 0, r};
    endfunction

    assign {r_fl, r_res} = addm(r_aa, r_ab, r_am);
    assign {f_fl, f_res} = addm(f_aa, f_ab, f_am);

    adder_arbiter #(.PRIO_MODE(0)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(q0v), .req0_ready_o(r_q0r), .req0_opr0_i(q0a), .req0_opr1_i(q0b), .req0_minus_i(q0m),
        .req1_valid_i(q1v), .req1_ready_o(r_q1r), .req1_opr0_i(q1a), .req1_opr1_i(q1b), .req1_minus_i(q1m),
        .add_opr0_o(r_aa), .add_opr1_o(r_ab), .add_minus_o(r_am), .add_result_i(r_res),
        .add_zero_i(r_fl[0]), .add_pos_i(r_fl[1]), .add_neg_i(r_fl[2]), .add_ovf_i(r_fl[3]),
        .resp0_valid_o(r_p0v), .resp0_ready_i(p0r), .resp0_result_o(r_p0d), .resp0_flags_o(r_p0f),
        .resp1_valid_o(r_p1v), .resp1_ready_i(p1r), .resp1_result_o(r_p1d), .resp1_flags_o(r_p1f)
    );

    adder_arbiter #(.PRIO_MODE(1)) u_fp (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(q0v), .req0_ready_o(f_q0r), .req0_opr0_i(q0a), .req0_opr1_i(q0b), .req0_minus_i(q0m),
        .req1_valid_i(q1v), .req1_ready_o(f_q1r), .req1_opr0_i(q1a), .req1_opr1_i(q1b), .req1_minus_i(q1m),
        .add_opr0_o(f_aa), .add_opr1_o(f_ab), .add_minus_o(f_am), .add_result_i(f_res),
        .add_zero_i(f_fl[0]), .add_pos_i(f_fl[1]), .add_neg_i(f_fl[2]), .add_ovf_i(f_fl[3]),
        .resp0_valid_o(f_p0v), .resp0_ready_i(p0r), .resp0_result_o(f_p0d), .resp0_flags_o(f_p0f),
        .resp1_valid_o(f_p1v), .resp1_ready_i(p1r), .resp1_result_o(f_p1d), .resp1_flags_o(f_p1f)
    );

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        n_fail++;
        $error("FAIL timeout: test did not finish in time");
        $finish;
    end

    initial begin
        rst = 1'b1;
        q0v = 0; q1v = 0; q0m = 0; q1m = 0; p0r = 0; p1r = 0;
        q0a = 0; q0b = 0; q1a = 0; q1b = 0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_p0v", r_p0v, 1'b0);
        chk("rst_p1v", r_p1v, 1'b0);
        chk("rst_p0d", r_p0d, 32'd0);
        chk("rst_p1f", r_p1f, 4'd0);
        chk("rst_aa", r_aa, 32'd0);
        chk("rst_am", r_am, 1'b0);

        // Port 0: 5 + 3
        q0v = 1; q0a = 32'd5; q0b = 32'd3; q0m = 0;
        #1;
        chk("p0_ready", r_q0r, 1'b1);
        chk("p1_ready_idle", r_q1r, 1'b0);
        chk("p0_aa", r_aa, 32'd5);
        chk("p0_ab", r_ab, 32'd3);
        chk("p0_am", r_am, 1'b0);
        step();
        q0v = 0;
        chk("p0_rv", r_p0v, 1'b1);
        chk("p0_res", r_p0d, 32'd8);
        chk("p0_flags", r_p0f, 4'b0010);

        // Port 1: 3 - 5, response held for 3 cycles
        q1v = 1; q1a = 32'd3; q1b = 32'd5; q1m = 1;
        #1;
        chk("p1_ready", r_q1r, 1'b1);
        chk("p1_am", r_am, 1'b1);
        step();
        q1a = 32'd10; q1b = 32'd1; q1m = 0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_rv", r_p1v, 1'b1);
            chk("hold_res", r_p1d, 32'hFFFF_FFFE);
            chk("hold_flags", r_p1f, 4'b0100);
            chk("hold_ready", r_q1r, 1'b0);
            step();
        end
        q1v = 0;

        // Consume both without new grants: valid drops, data kept
        p0r = 1; p1r = 1;
        step();
        chk("cons_p0v", r_p0v, 1'b0);
        chk("cons_p1v", r_p1v, 1'b0);
        chk("cons_p0d", r_p0d, 32'd8);
        chk("cons_p1d", r_p1d, 32'hFFFF_FFFE);

        // Contention from reset: round-robin alternates, fixed keeps port 0
        rst = 1;
        step();
        rst = 0;
        q0v = 1; q1v = 1; q0m = 0; q1m = 0;
        for (int k = 0; k < 4; k++) begin
            q0a = 32'(10 * k); q0b = 32'd1;
            q1a = 32'd1000;    q1b = 32'(k);
            #1;
            chk("rr_q0r", r_q0r, (k % 2 == 0));
            chk("rr_q1r", r_q1r, (k % 2 == 1));
            chk("fp_q0r", f_q0r, 1'b1);
            chk("fp_q1r", f_q1r, 1'b0);
            step();
            if (k % 2 == 0) begin
                chk("rr_resp0", r_p0d, 32'(10 * k + 1));
                chk("rr_resp0v", r_p0v, 1'b1);
            end else begin
                chk("rr_resp1", r_p1d, 32'(1000 + k));
                chk("rr_resp1v", r_p1v, 1'b1);
            end
            chk("fp_resp0", f_p0d, 32'(10 * k + 1));
        end
        chk("fp_no_p1", f_p1v, 1'b0);
        q0v = 0; q1v = 0;
        step();

        // Pass-through: consume and re-grant in the same cycle
        p0r = 0;
        q0v = 1; q0a = 32'd2; q0b = 32'd2;
        step();
        chk("pt_pend", r_p0d, 32'd4);
        q0a = 32'd7; q0b = 32'd7; p0r = 1;
        #1;
        chk("pt_ready", r_q0r, 1'b1);
        step();
        q0v = 0; p0r = 0;
        chk("pt_rv", r_p0v, 1'b1);
        chk("pt_res", r_p0d, 32'd14);
        chk("pt_flags", r_p0f, 4'b0010);

        // Reset wins over a simultaneous grant to port 1
        p1r = 0;
        q1v = 1; q1a = 32'd9; q1b = 32'd9; q1m = 0;
        #1;
        chk("rg_q1r", r_q1r, 1'b1);
        rst = 1;
        step();
        rst = 0; q1v = 0;
        chk("rg_p0v", r_p0v, 1'b0);
        chk("rg_p1v", r_p1v, 1'b0);
        chk("rg_p0d", r_p0d, 32'd0);
        chk("rg_p1d", r_p1d, 32'd0);
        chk("rg_p0f", r_p0f, 4'd0);
        chk("rg_fp_p1d", f_p1d, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
# adder_arbiter

Shares a single 32-bit add/subtract datapath between two requesters (port 0: execute-stage ALU, port 1: address/branch-target unit). It arbitrates per cycle and drives the shared adder's operand and `minus` inputs combinationally from the winning request. It captures the adder's result and flags into a per-port response register held until the requester accepts it. The adder itself stays outside this block.

## Interface

- `PRIO_MODE`, default 0: 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.
- `clk_i` in, 1: clock; all state updates on its rising edge.
- `rst_i` in, 1: reset. Synchronous and active-high.
- `reqN_valid_i` in, 1 (N = 0,1): request present.
- `reqN_ready_o` out, 1: request accepted this cycle when high together with `reqN_valid_i`.
- `reqN_opr0_i` in, 32: first operand.
- `reqN_opr1_i` in, 32: second operand.
- `reqN_minus_i` in, 1: 1 = subtract (opr0 − opr1), 0 = add.
- `add_opr0_o` out, 32: to shared adder, first operand.
- `add_opr1_o` out, 32: to shared adder, second operand.
- `add_minus_o` out, 1: to shared adder, subtract select.
- `add_result_i` in, 32: from shared adder, sum/difference.
- `add_zero_i`, `add_pos_i`, `add_neg_i`, `add_ovf_i` in, 1 each: from shared adder, flags.
- `respN_valid_o` out, 1: response register N holds an unconsumed result.
- `respN_ready_i` in, 1: requester N consumes its response this cycle.
- `respN_result_o` out, 32: registered result.
- `respN_flags_o` out, 4: registered flags {ovf, neg, pos, zero}.

## Operation

- Port N is eligible when `reqN_valid_i`=1 and its slot is free. A slot is free when `respN_valid_o`=0, or when `respN_valid_o`=1 and `respN_ready_i`=1 in the same cycle (pass-through free).
- Arbitration is combinational within the cycle.
  - Exactly zero or one port is granted.
  - `reqN_ready_o`=1 only for the granted port.
  - A non-eligible port never sees `reqN_ready_o`=1.
- `reqN_ready_o` may depend combinationally on both valids and both `respN_ready_i`.
- Round-robin (`PRIO_MODE`=0):
  - 1-bit `last_grant` register.
  - When both ports are eligible, grant goes to the port ≠ `last_grant`.
  - When one port is eligible, it wins regardless of `last_grant`.
  - `last_grant` updates to the granted port on every grant and holds otherwise.
- Fixed (`PRIO_MODE`=1): port 0 wins whenever eligible. `last_grant` is unused.
- Adder drive:
  - When a grant is made, `add_opr0_o`/`add_opr1_o`/`add_minus_o` equal the granted port's inputs in the same cycle.
  - With no grant, the adder inputs are driven to 0/0/0 (deterministic, no X propagation).
- Capture: at the edge closing a grant cycle, response register N loads `add_result_i` and flags {ovf, neg, pos, zero}, and sets `respN_valid_o`=1.
- Flags are forwarded unmodified; this block performs no arithmetic.
- Hold: while `respN_valid_o`=1 and `respN_ready_i`=0, the result and flags are frozen.
- Consume without a new grant: `respN_valid_o` clears to 0; the result and flags keep their last values.
- Consume and a new grant in the same cycle: the register reloads with the new result and `respN_valid_o` stays 1.
- Port 0 and port 1 response registers are independent. One port stalling its response never blocks the other port.

## Timing

- Reset (rst_i=1 at an edge):
  - `respN_valid_o`=0, `respN_result_o`=0, `respN_flags_o`=0.
  - `last_grant`=1, so port 0 wins the first contention.
  - Combinational outputs follow from this state.
- `rst_i` overrides everything, including a grant in the same cycle: nothing is captured.
- Any in-flight response is discarded by reset.
- Latency: accept in cycle T → `respN_valid_o`=1 in cycle T+1.
- Throughput: one accepted operation per cycle total.
- A single port sustains one per cycle when its `respN_ready_i` is held high.
- Under continuous contention with both response ready inputs high, grants alternate 0,1,0,1…

## Test plan

- Reset, then port 0 presents 5 + 3 (minus=0) with port 1 idle:
  - `req0_ready_o`=1 the same cycle; adder sees 5/3/0.
  - Next cycle `resp0_valid_o`=1, `resp0_result_o`=8, zero=0, pos=1, neg=0.
- Port 1 presents 3 − 5 (minus=1) with `resp1_ready_i`=0 for 3 cycles:
  - Result 0xFFFFFFFE, neg=1, pos=0, frozen all 3 cycles.
  - `req1_ready_o`=0 for a second valid request during the hold.
- Both ports valid for 4 consecutive cycles with both response readies high (`PRIO_MODE`=0, from reset):
  - Grants go 0,1,0,1.
  - Each response appears one cycle after its grant with the correct sums.
- Same as previous with `PRIO_MODE`=1: port 0 granted all 4 cycles; `req1_ready_o`=0 throughout.
- Port 0 holds a pending response; `resp0_ready_i`=1 and a new request 7 + 7 arrive in the same cycle:
  - The request is granted.
  - Next cycle `resp0_valid_o` stays 1 with result 14 (no bubble).
- `rst_i` asserted in the same cycle as a grant to port 1 with `resp0_valid_o`=1 pending:
  - After the edge, both response valids are 0, results and flags are 0, and no capture occurred.
